scan_sequencer: RTL and testbench

Registered channel scanner that drives the select/enable inputs of the 2-to-4 decoder stage. It steps a 2-bit channel select through the set bits of a captured 4-bit channel mask in ascending order and wraps around. Each channel is held for a programmable dwell time. The decoder directly downstream turns `sel`/`en` into a one-hot line, so this block fully determines which output line is active and for how long.

---
 rtl/scan_if.sv | 33 +++
 rtl/scan_sequencer.sv | 143 ++++++++++++++
 tb/tb_scan_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_if.sv
// ---------------------------------------------------------------------------
// scan_if
// Bundles the scan_sequencer control inputs and decoder-facing outputs.
//   start, stop : scan control requests, sampled every clock
//   ch_mask     : channels to visit (bit i enables channel i)
//   dwell       : per-channel hold time minus one
//   sel, en     : channel index and enable for the 2-to-4 decoder
//   busy        : high while scanning
//   wrap        : one-cycle pulse at the end of each full pass
// Modports: master drives the controls, slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface scan_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [3:0]         ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         sel;
  logic               en;
  logic               busy;
  logic               wrap;

  modport master (
    output start, stop, ch_mask, dwell,
    input  sel, en, busy, wrap
  );

  modport slave (
    input  start, stop, ch_mask, dwell,
    output sel, en, busy, wrap
  );
endinterface

// File: rtl/scan_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sequencer
// Steps a 2-bit channel select through the set bits of a captured 4-bit mask
// in ascending order, wrapping around, holding each channel dwell+1 cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : scan_if.slave (start/stop/ch_mask/dwell in; sel/en/busy/wrap out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  scan_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_r;
  logic [3:0]         mask_r;
  logic [DWELL_W-1:0] reload_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [1:0]         sel_r;
  logic               en_r;
  logic               busy_r;
  logic               wrap_r;

  logic [1:0]         next_sel_s;
  logic               next_wraps_s;

  // Index of the lowest set bit; only meaningful for a non-zero mask.
  function automatic logic [1:0] lowest_set(input logic [3:0] mask);
    logic [1:0] res;
    if (mask[0]) begin
      res = 2'd0;
    end else if (mask[1]) begin
      res = 2'd1;
    end else if (mask[2]) begin
      res = 2'd2;
    end else begin
      res = 2'd3;
    end
    return res;
  endfunction

  // Next set bit strictly above cur, modulo 4; returns cur when it is the only one.
  function automatic logic [1:0] next_index(input logic [3:0] mask, input logic [1:0] cur);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;
    logic [1:0] res;
    c1 = cur + 2'd1;
    c2 = cur + 2'd2;
    c3 = cur + 2'd3;
    if (mask[c1]) begin
      res = c1;
    end else if (mask[c2]) begin
      res = c2;
    end else if (mask[c3]) begin
      res = c3;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Advance target and pass-completion flag; moving to an index not above
  // the current one means we just left the highest set bit for the lowest.
  always_comb begin
    next_sel_s   = next_index(mask_r, sel_r);
    next_wraps_s = (next_sel_s <= sel_r);
  end

  // Scan state machine with registered decoder-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mask_r   <= 4'b0000;
      reload_r <= '0;
      cnt_r    <= '0;
      sel_r    <= 2'b00;
      en_r     <= 1'b0;
      busy_r   <= 1'b0;
      wrap_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wrap_r <= 1'b0;
          // stop has priority over start, and an empty mask is never entered
          if (bus.start && !bus.stop && (bus.ch_mask != 4'b0000)) begin
            state_r  <= SCAN;
            mask_r   <= bus.ch_mask;
            reload_r <= bus.dwell;
            cnt_r    <= bus.dwell;
            sel_r    <= lowest_set(bus.ch_mask);
            en_r     <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        SCAN: begin
          if (bus.stop) begin
            // sel deliberately holds its last value
            state_r <= IDLE;
            cnt_r   <= '0;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            wrap_r  <= 1'b0;
          end else if (cnt_r != '0) begin
            cnt_r  <= cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
            wrap_r <= 1'b0;
          end else begin
            cnt_r  <= reload_r;
            sel_r  <= next_sel_s;
            wrap_r <= next_wraps_s;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          sel_r   <= 2'b00;
          en_r    <= 1'b0;
          busy_r  <= 1'b0;
          wrap_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel  = sel_r;
  assign bus.en   = en_r;
  assign bus.busy = busy_r;
  assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scan_sequencer
// Self-checking bench: a constant vector table, hand-written corner-case
// sequences and randomized stimulus, all compared every cycle against a
// pass/position reference model plus a 2-to-4 decoder fed from sel/en.
// ---------------------------------------------------------------------------
module tb_scan_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  scan_if #(.DWELL_W(8)) bus ();

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: the scan is a position t since start; the channel is the
  // (t / (dwell+1))-th entry (mod n) of the list of set mask bits.
  bit m_active;
  int m_t;
  int m_n;
  int m_dw;
  int m_lst[4];
  int m_sel;

  typedef struct {
    logic       start;
    logic       stop;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       wrap;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_n      = 0;
    m_dw     = 0;
    m_sel    = 0;
  endtask

  task automatic model_edge();
    if (m_active) begin
      if (bus.stop) begin
        m_active = 1'b0;
      end else begin
        m_t++;
        m_sel = m_lst[(m_t / (m_dw + 1)) % m_n];
      end
    end else if (bus.start && !bus.stop && bus.ch_mask != 4'b0000) begin
      m_active = 1'b1;
      m_t      = 0;
      m_dw     = int'(bus.dwell);
      m_n      = 0;
      for (int i = 0; i < 4; i++) begin
        if (bus.ch_mask[i]) begin
          m_lst[m_n] = i;
          m_n++;
        end
      end
      m_sel = m_lst[0];
    end
  endtask

  task automatic check_outputs();
    logic [3:0] dec;
    int exp_wrap;
    exp_wrap = (m_active && m_t > 0 && (m_t % (m_n * (m_dw + 1))) == 0) ? 1 : 0;
    chk("sel",  int'(bus.sel),  m_sel);
    chk("en",   int'(bus.en),   m_active ? 1 : 0);
    chk("busy", int'(bus.busy), m_active ? 1 : 0);
    chk("wrap", int'(bus.wrap), exp_wrap);
    dec = bus.en ? (4'b0001 << bus.sel) : 4'b0000;
    chk("dec_lines", $countones(dec), m_active ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic st, input logic sp, input logic [3:0] m, input logic [7:0] d);
    bus.start   = st;
    bus.stop    = sp;
    bus.ch_mask = m;
    bus.dwell   = d;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 8'd0);
    model_reset();

    // reset values while rst_n is held low
    #1;
    chk("rst_sel",  int'(bus.sel),  0);
    chk("rst_en",   int'(bus.en),   0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // {start, stop, mask, dwell, exp sel, en, busy, wrap}
    tbl[0]  = '{1'b0, 1'b0, 4'b0000, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b0000, 8'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'b1010, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'b1010, 8'd0, 2'd1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b1010, 8'd0, 2'd3, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b1010, 8'd0, 2'd1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 4'b1111, 8'd7, 2'd3, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b0001, 8'd3, 2'd1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 4'b1010, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'b1010, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'b0100, 8'd3, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'b0100, 8'd3, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'b0100, 8'd3, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'b0100, 8'd3, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'b0100, 8'd3, 2'd2, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'b0100, 8'd3, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 4'b0100, 8'd3, 2'd2, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].mask, tbl[i].dwell);
      cycle();
      chk($sformatf("tbl%0d_sel", i),  int'(bus.sel),  int'(tbl[i].sel));
      chk($sformatf("tbl%0d_en", i),   int'(bus.en),   int'(tbl[i].en));
      chk($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_wrap", i), int'(bus.wrap), int'(tbl[i].wrap));
    end
    drive(1'b0, 1'b0, 4'b0000, 8'd0);
    cycle();

    // full mask, dwell 2: sel 0,0,0,1,1,1,... wrap every 12 cycles
    drive(1'b1, 1'b0, 4'b1111, 8'd2);
    cycle();
    drive(1'b0, 1'b0, 4'b0000, 8'd9);
    for (int t = 1; t <= 26; t++) begin
      cycle();
      chk("full_sel_seq", int'(bus.sel), (t / 3) % 4);
      chk("full_wrap_seq", int'(bus.wrap), (t % 12 == 0) ? 1 : 0);
    end

    // stop mid-dwell, then restart with new captured values
    drive(1'b1, 1'b1, 4'b1111, 8'd5);
    cycle();
    drive(1'b0, 1'b0, 4'b1111, 8'd5);
    cycle();
    cycle();
    drive(1'b1, 1'b0, 4'b1111, 8'd5);
    cycle();
    drive(1'b0, 1'b0, 4'b0000, 8'd0);
    repeat (9) cycle();
    drive(1'b0, 1'b1, 4'b0000, 8'd0);
    cycle();
    chk("stop_en_low", int'(bus.en), 0);
    drive(1'b1, 1'b0, 4'b0011, 8'd1);
    cycle();
    drive(1'b0, 1'b0, 4'b1000, 8'd4);
    repeat (6) cycle();

    // asynchronous reset mid-scan, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel",  int'(bus.sel),  0);
    chk("arst_en",   int'(bus.en),   0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_wrap", int'(bus.wrap), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 4)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
